// File: rtl/i2c_target_regfile.sv
// I2C target exposing NUM_REGS 8-bit registers through an auto-incrementing pointer; bus lines are synchronised then glitch-filtered.
// Latency: SYNC_STAGES+FILT_LEN clks from a pin to decode; the target never stretches SCL, so no backpressure is applied.
module i2c_target_regfile #(
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [6:0]            slave_addr,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  wr_stb,
  output logic [7:0]            wr_idx,
  output logic                  busy
);

  localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  logic [1:0]             line_in;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CW-1:0]          cnt_q [2];
  logic [1:0]             filt_q, prev_q;   // bit 0 = SCL, bit 1 = SDA

  assign line_in = {sda_in, scl_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      filt_q <= 2'b11;
      prev_q <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], line_in[i]};
        if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= sync_q[i][SYNC_STAGES-1];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
      prev_q <= filt_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_f;
  assign sda_f     = filt_q[1];
  assign scl_rise  = filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] & prev_q[0];
  assign start_det = prev_q[1] & ~filt_q[1] & filt_q[0];
  assign stop_det  = ~prev_q[1] & filt_q[1] & filt_q[0];

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, phase_q, phase_d;
  logic          wr_stb_q, wr_stb_d, reg_we;
  logic [7:0]    wr_idx_q, wr_idx_d, rx_byte;
  logic [7:0]    regs_q [NUM_REGS];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    reg_we    = 1'b0;
    rx_byte   = {shift_q[6:0], sda_f};
    ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd7;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end else begin
              bit_cnt_d = 3'd7;
              if (state_q == ADDR) begin
                // Address 0 is the general call and is never claimed.
                if (rx_byte[7:1] == slave_addr && rx_byte[7:1] != 7'd0) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                  ptr_d   = rx_byte[PW-1:0];
                  state_d = PTR_ACK;
                end else begin
                  state_d = WAIT_STOP;
                end
              end else begin
                reg_we   = 1'b1;
                wr_stb_d = 1'b1;
                wr_idx_d = 8'(ptr_q);
                ptr_d    = ptr_inc;
                state_d  = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First SCL fall opens the ACK slot, the second closes it.
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd7;
              sda_oe_d  = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d  = RDATA;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) begin
              state_d = RACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        RACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_f) begin
              ptr_d     = ptr_inc;
              shift_d   = regs_q[ptr_inc];
              bit_cnt_d = 3'd7;
              state_d   = RDATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd7;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      phase_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      phase_q   <= phase_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      if (reg_we) regs_q[ptr_q] <= rx_byte;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[8*g +: 8] = regs_q[g];
  end

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 8-bit registers (2..256).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on scl_in/sda_in (>=2).
REQ-003 SHALL have parameter FILT_LEN, default 3, consecutive equal samples required before a filtered line changes (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port scl_in  input  1  raw bus SCL level.
REQ-007 SHALL have port sda_in  input  1  raw bus SDA level.
REQ-008 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-009 SHALL have port slave_addr  input  7  own 7-bit address, sampled at each address compare.
REQ-010 SHALL have port reg_q  output  8*NUM_REGS  register file contents, reg i at bits [8i+7:8i].
REQ-011 SHALL have port wr_stb  output  1  one-clk pulse when a data byte is written to the file.
REQ-012 SHALL have port wr_idx  output  8  index written; valid when wr_stb=1.
REQ-013 SHALL have port busy  output  1  high from addressed START until STOP or NACKed address.

Function
REQ-014 SHALL synchronise scl_in/sda_in through SYNC_STAGES flops, then glitch-filter by FILT_LEN; all decoding uses filtered scl_f/sda_f and their one-clk edge pulses.
REQ-015 SHALL detect START as sda_f falling while scl_f high, STOP as sda_f rising while scl_f high; either is honoured in every state, START overrides any transfer in progress (repeated START).
REQ-016 SHALL sample SDA on scl_f rising edge, MSB first; SHALL change sda_oe only on scl_f falling edge.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-018 IDLE->ADDR on START; bit counter reset to 7.
REQ-019 ADDR: after 8th bit, if bits[7:1]==slave_addr go ADDR_ACK (sda_oe=1 from next scl fall for one bit period), busy=1; else WAIT_STOP, sda_oe=0.
REQ-020 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, loading reg[ptr] as shift byte.
REQ-021 PTR: received byte < NUM_REGS -> ptr<=byte, ACK, then WDATA; byte >= NUM_REGS -> NACK (sda_oe=0 during ACK slot), ptr unchanged, WAIT_STOP.
REQ-022 WDATA: after 8th bit, reg[ptr]<=byte, wr_stb=1 with wr_idx=ptr for exactly one clk, ACK, ptr<=(ptr+1) mod NUM_REGS, remain in WDATA for further bytes.
REQ-023 RDATA: drive sda_oe = ~bit (release for 1, pull for 0) per bit; after 8 bits release and enter RACK.
REQ-024 RACK: master ACK (sda_f=0 at scl rise) -> ptr<=(ptr+1) mod NUM_REGS, load reg[ptr+1], RDATA; master NACK -> WAIT_STOP.
REQ-025 ptr SHALL persist across transactions (a write setting ptr followed by repeated START read reads from that ptr).
REQ-026 STOP in any state -> IDLE, sda_oe=0, busy=0; partial byte discarded, no register written.
REQ-027 WAIT_STOP: sda_oe=0, ignore bits, exit only on STOP or START.
REQ-028 General-call address 0x00 SHALL be NACKed.

Reset
REQ-029 With rst_n=0 at a clk edge: state=IDLE, sda_oe=0, busy=0, wr_stb=0, wr_idx=0, ptr=0, all reg_q=0x00, synchroniser/filter flops=1 (bus idle-high).
REQ-030 Reset mid-transfer SHALL release SDA on the next clk edge; block resumes only on a fresh START.

Verification
REQ-031 slave_addr=0x42; S,0x84,0x01,0xA5,0x5A,P -> ACK x4, reg1=0xA5, reg2=0x5A, two wr_stb pulses idx 1 then 2.
REQ-032 After REQ-031: S,0x84,0x03,Sr,0x85, read 2 bytes ACK then NACK,P -> bytes reg3=0x00 then reg0 (wrap), sda released after NACK.
REQ-033 S,0x86 (addr 0x43),0xFF,P -> NACK on address, sda_oe never asserted, no wr_stb, busy stays 0.
REQ-034 S,0x84,0x04 (NUM_REGS=4) -> pointer NACKed, following data byte ignored, ptr unchanged.
REQ-035 1-clk glitch on scl_in during data bit with FILT_LEN=3 -> no extra bit counted; STOP mid-byte -> IDLE, no write.
REQ-036 rst_n low for one clk during ADDR_ACK -> sda_oe=0 next clk, all regs 0x00, next valid transaction completes normally.
